// File: rtl/alu_sequencer_pkg.sv
// Shared types for the ALU sequencer: opcodes, FSM states, instruction field
// positions and the per-opcode operand-enable / flag decode.
package alu_sequencer_pkg;

    localparam int INSTR_W = 24;
    localparam int FIELD_W = 4;
    localparam int IMM_W   = 8;
    localparam int REN_W   = 5;

    localparam int OP_LSB  = 20;
    localparam int RD_LSB  = 16;
    localparam int RS_LSB  = 12;
    localparam int RT_LSB  = 8;
    localparam int IMM_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LDSW = 4'd1,
        OP_ADDI = 4'd2,
        OP_MUL  = 4'd3,
        OP_MAC  = 4'd4
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_WB
    } state_e;

    // reg_en bit order: [0] a, [1] b, [2] c, [3] d, [4] e
    localparam logic [REN_W-1:0] REN_LDSW = 5'b10000;
    localparam logic [REN_W-1:0] REN_ADDI = 5'b10000;
    localparam logic [REN_W-1:0] REN_MUL  = 5'b10011;
    localparam logic [REN_W-1:0] REN_MAC  = 5'b11111;

    typedef struct packed {
        logic [REN_W-1:0] reg_en;
        logic             f_add;
        logic             f_load;
    } ctrl_t;

    // Opcodes that occupy the READ/CAPT/WB sequence.
    function automatic logic op_is_exec(input logic [FIELD_W-1:0] op);
        return (op >= OP_LDSW) && (op <= OP_MAC);
    endfunction

    function automatic logic op_is_undef(input logic [FIELD_W-1:0] op);
        return op > OP_MAC;
    endfunction

    function automatic ctrl_t op_ctrl(input logic [FIELD_W-1:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_LDSW: c = '{reg_en: REN_LDSW, f_add: 1'b0, f_load: 1'b0};
            OP_ADDI: c = '{reg_en: REN_ADDI, f_add: 1'b1, f_load: 1'b1};
            OP_MUL:  c = '{reg_en: REN_MUL,  f_add: 1'b0, f_load: 1'b1};
            OP_MAC:  c = '{reg_en: REN_MAC,  f_add: 1'b1, f_load: 1'b1};
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake plus ALU / register-file control bundle.
interface alu_sequencer_if
    import alu_sequencer_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = 16
);
    logic                 instr_valid;
    logic [INSTR_W-1:0]   instr;
    logic                 instr_ready;
    logic [FIELD_W-1:0]   rs_addr;
    logic [FIELD_W-1:0]   rt_addr;
    logic [BUS_WIDTH-1:0] imm;
    logic [REN_W-1:0]     reg_en;
    logic                 f_add;
    logic                 f_load;
    logic                 wr_en;
    logic [FIELD_W-1:0]   wr_addr;
    logic                 busy;
    logic                 illegal;
    logic [CNT_WIDTH-1:0] retired;

    modport master (
        output instr_valid, instr,
        input  instr_ready, rs_addr, rt_addr, imm, reg_en, f_add, f_load,
               wr_en, wr_addr, busy, illegal, retired
    );

    modport slave (
        input  instr_valid, instr,
        output instr_ready, rs_addr, rt_addr, imm, reg_en, f_add, f_load,
               wr_en, wr_addr, busy, illegal, retired
    );

endinterface

// File: rtl/alu_sequencer.sv
// Four-state instruction sequencer: accepts one instruction in IDLE, then steps
// register read, operand capture and write-back, counting retired write-backs.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input logic            clk,
    input logic            rst_n,
    alu_sequencer_if.slave bus
);

    state_e               state_q, state_d;
    ctrl_t                ctrl_q;
    logic [FIELD_W-1:0]   rd_q, rs_q, rt_q;
    logic [BUS_WIDTH-1:0] imm_q;
    logic                 illegal_q;
    logic [CNT_WIDTH-1:0] retired_q;

    logic [FIELD_W-1:0]   op_in;
    logic                 ready;
    logic                 accept;
    logic                 start;
    logic                 busy;
    logic [REN_W-1:0]     reg_en;
    logic                 wr_en;

    assign op_in  = bus.instr[OP_LSB +: FIELD_W];
    assign accept = bus.instr_valid && ready;
    assign start  = accept && op_is_exec(op_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            rd_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            imm_q     <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= accept && op_is_undef(op_in);
            // Fields are captured only for executing opcodes, so NOPs and
            // undefined opcodes leave the previous operands visible.
            if (start) begin
                ctrl_q <= op_ctrl(op_in);
                rd_q   <= bus.instr[RD_LSB +: FIELD_W];
                rs_q   <= bus.instr[RS_LSB +: FIELD_W];
                rt_q   <= bus.instr[RT_LSB +: FIELD_W];
                imm_q  <= BUS_WIDTH'(bus.instr[IMM_LSB +: IMM_W]);
            end
            if (state_q == S_WB)
                retired_q <= retired_q + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        busy    = 1'b0;
        reg_en  = '0;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (start)
                    state_d = S_READ;
            end
            S_READ: begin
                busy    = 1'b1;
                state_d = S_CAPT;
            end
            S_CAPT: begin
                busy    = 1'b1;
                reg_en  = ctrl_q.reg_en;
                state_d = S_WB;
            end
            S_WB: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.instr_ready = ready;
    assign bus.busy        = busy;
    assign bus.reg_en      = reg_en;
    assign bus.wr_en       = wr_en;
    assign bus.wr_addr     = rd_q;
    assign bus.rs_addr     = rs_q;
    assign bus.rt_addr     = rt_q;
    assign bus.imm         = imm_q;
    assign bus.f_add       = busy && ctrl_q.f_add;
    assign bus.f_load      = busy && ctrl_q.f_load;
    assign bus.illegal     = illegal_q;
    assign bus.retired     = retired_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: vector table, write-back scoreboard,
// and hand-written back-to-back, reset-abort, NOP-stream and counter-wrap cases.
module tb_alu_sequencer;

    // Narrow retired counter so its wrap is reachable in a short run.
    localparam int CW = 4;

    logic clk;
    logic rst_n;

    alu_sequencer_if #(.BUS_WIDTH(8), .CNT_WIDTH(CW)) bus ();

    alu_sequencer #(.BUS_WIDTH(8), .CNT_WIDTH(CW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [7:0] imm;
        logic [4:0] ren;
        logic       fa;
        logic       fl;
        logic       ill;
    } vec_t;

    int         nchk = 0;
    int         nerr = 0;
    logic [3:0] sb_q[$];
    logic [CW-1:0] exp_ret = '0;
    vec_t       vt[8];
    vec_t       mulv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard: every write-back must match the oldest outstanding destination.
    always @(negedge clk) begin
        if (rst_n && bus.wr_en) begin
            if (sb_q.size() == 0) begin
                chk("wb_unexpected", 32'd1, 32'd0);
            end else begin
                chk("wb_addr", bus.wr_addr, sb_q.pop_front());
            end
            chk("wb_retired_before", bus.retired, exp_ret);
            exp_ret = exp_ret + 1'b1;
        end
    end

    task automatic run_vec(input vec_t v);
        logic run;
        run = (v.op >= 4'd1) && (v.op <= 4'd4);
        tick();
        chk("ready_idle", bus.instr_ready, 1);
        bus.instr_valid = 1'b1;
        bus.instr       = {v.op, v.rd, v.rs, v.rt, v.imm};
        if (run) sb_q.push_back(v.rd);
        tick();
        bus.instr_valid = 1'b0;
        bus.instr       = 24'($urandom);
        if (run) begin
            chk("read_busy", bus.busy, 1);
            chk("read_ready", bus.instr_ready, 0);
            chk("read_rs", bus.rs_addr, v.rs);
            chk("read_rt", bus.rt_addr, v.rt);
            chk("read_imm", bus.imm, v.imm);
            chk("read_ren", bus.reg_en, 0);
            chk("read_fadd", bus.f_add, v.fa);
            chk("read_fload", bus.f_load, v.fl);
            chk("read_illegal", bus.illegal, 0);
            tick();
            chk("capt_ren", bus.reg_en, v.ren);
            chk("capt_fadd", bus.f_add, v.fa);
            chk("capt_fload", bus.f_load, v.fl);
            chk("capt_wren", bus.wr_en, 0);
            tick();
            chk("wb_wren", bus.wr_en, 1);
            chk("wb_ren", bus.reg_en, 0);
            chk("wb_fadd", bus.f_add, v.fa);
            chk("wb_fload", bus.f_load, v.fl);
            chk("wb_rs_stable", bus.rs_addr, v.rs);
            tick();
            chk("post_busy", bus.busy, 0);
            chk("post_wren", bus.wr_en, 0);
            chk("post_retired", bus.retired, exp_ret);
        end else begin
            chk("nx_illegal", bus.illegal, v.ill);
            chk("nx_busy", bus.busy, 0);
            chk("nx_ready", bus.instr_ready, 1);
            chk("nx_ren", bus.reg_en, 0);
            tick();
            chk("nx_illegal_end", bus.illegal, 0);
            chk("nx_wren", bus.wr_en, 0);
            chk("nx_retired", bus.retired, exp_ret);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{4'd3, 4'd5,  4'd2,  4'd3,  8'h00, 5'b10011, 1'b0, 1'b1, 1'b0};
        vt[1] = '{4'd2, 4'd1,  4'd4,  4'd0,  8'h7F, 5'b10000, 1'b1, 1'b1, 1'b0};
        vt[2] = '{4'd1, 4'd15, 4'd6,  4'd9,  8'h11, 5'b10000, 1'b0, 1'b0, 1'b0};
        vt[3] = '{4'd4, 4'd9,  4'd7,  4'd8,  8'hA5, 5'b11111, 1'b1, 1'b1, 1'b0};
        vt[4] = '{4'hA, 4'd2,  4'd3,  4'd4,  8'h55, 5'b00000, 1'b0, 1'b0, 1'b1};
        vt[5] = '{4'd0, 4'd7,  4'd1,  4'd1,  8'h33, 5'b00000, 1'b0, 1'b0, 1'b0};
        vt[6] = '{4'hF, 4'd8,  4'd8,  4'd8,  8'hFF, 5'b00000, 1'b0, 1'b0, 1'b1};
        vt[7] = '{4'd4, 4'd0,  4'd15, 4'd15, 8'hFF, 5'b11111, 1'b1, 1'b1, 1'b0};
        mulv  = '{4'd3, 4'd12, 4'd1,  4'd2,  8'h00, 5'b10011, 1'b0, 1'b1, 1'b0};

        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_ready", bus.instr_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_wren", bus.wr_en, 0);
        chk("rst_illegal", bus.illegal, 0);
        chk("rst_ren", bus.reg_en, 0);
        chk("rst_fadd", bus.f_add, 0);
        chk("rst_fload", bus.f_load, 0);
        chk("rst_imm", bus.imm, 0);
        chk("rst_rs", bus.rs_addr, 0);
        chk("rst_rt", bus.rt_addr, 0);
        chk("rst_wraddr", bus.wr_addr, 0);
        chk("rst_retired", bus.retired, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vt[i]);

        // Back-to-back ADDI then LDSW with instr_valid held high.
        tick();
        bus.instr_valid = 1'b1;
        bus.instr       = {4'd2, 4'd3, 4'd5, 4'd6, 8'h7F};
        sb_q.push_back(4'd3);
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) begin
                bus.instr = {4'd1, 4'd6, 4'd0, 4'd0, 8'h00};
                sb_q.push_back(4'd6);
            end
            if (c == 5) bus.instr_valid = 1'b0;
            chk($sformatf("b2b_ready_c%0d", c), bus.instr_ready, (c == 4 || c == 8) ? 1 : 0);
            chk($sformatf("b2b_wren_c%0d", c), bus.wr_en, (c == 3 || c == 7) ? 1 : 0);
            if (c <= 3) chk($sformatf("b2b_imm_c%0d", c), bus.imm, 8'h7F);
        end
        chk("b2b_retired", bus.retired, exp_ret);

        // Reset in the capture cycle of a MAC aborts it.
        tick();
        bus.instr_valid = 1'b1;
        bus.instr       = {4'd4, 4'd4, 4'd2, 4'd3, 8'h99};
        tick();
        bus.instr_valid = 1'b0;
        tick();
        chk("abort_capt_ren", bus.reg_en, 5'b11111);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_ren", bus.reg_en, 0);
        chk("abort_wren", bus.wr_en, 0);
        chk("abort_fadd", bus.f_add, 0);
        chk("abort_fload", bus.f_load, 0);
        chk("abort_imm", bus.imm, 0);
        chk("abort_rs", bus.rs_addr, 0);
        chk("abort_retired", bus.retired, 0);
        exp_ret = '0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("abort_post_ready", bus.instr_ready, 1);
            chk("abort_post_wren", bus.wr_en, 0);
            chk("abort_post_retired", bus.retired, 0);
        end

        // NOP stream with instr_valid held high.
        bus.instr_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.instr = {4'd0, 20'($urandom)};
            tick();
            chk("nop_ready", bus.instr_ready, 1);
            chk("nop_busy", bus.busy, 0);
            chk("nop_ren", bus.reg_en, 0);
            chk("nop_illegal", bus.illegal, 0);
        end
        bus.instr_valid = 1'b0;

        // Drive the retired counter to all-ones, then one more wraps it to zero.
        for (int i = 0; i < (1 << CW) - 1; i++) run_vec(mulv);
        chk("wrap_allones", bus.retired, {CW{1'b1}});
        run_vec(mulv);
        chk("wrap_zero", bus.retired, 0);

        tick();
        chk("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
